sync_fifo_param: RTL and testbench

//  Single-clock, parametrised FIFO; same-clock successor to async_fifo_top.

---
 rtl/sync_fifo_param.sv | 82 ++++++++
 tb/tb_sync_fifo_param.sv | 110 +++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO with programmable thresholds,
// occupancy count, sticky overflow/underflow flags and optional
// first-word-fall-through read mode (enabled by defining FWFT_EN).
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = 12,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_CNT   = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_CNT   = (ADDR_WIDTH+1)'(AE_THRESH);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr, count_nxt;
    logic                  wr_acc, rd_acc;
    // acceptance: a pop frees a slot so a write into a full FIFO still lands
    always_comb begin
        rd_acc    = rd_en & ~empty;
        wr_acc    = wr_en & (~full | rd_acc);
        count_nxt = count + {{ADDR_WIDTH{1'b0}}, wr_acc} - {{ADDR_WIDTH{1'b0}}, rd_acc};
    end
    // storage array, deliberately not reset
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc)
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= din;
    end
    // pointers, occupancy, registered flags and sticky error flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr + {{ADDR_WIDTH{1'b0}}, wr_acc};
            rd_ptr       <= rd_ptr + {{ADDR_WIDTH{1'b0}}, rd_acc};
            count        <= count_nxt;
            full         <= count_nxt == FULL_CNT;
            empty        <= count_nxt == '0;
            almost_full  <= count_nxt >= AF_CNT;
            almost_empty <= count_nxt <= AE_CNT;
            overflow     <= overflow | (wr_en & ~wr_acc);
            underflow    <= underflow | (rd_en & empty);
        end
    end
`ifdef FWFT_EN
    assign dout       = empty ? '0 : mem[rd_ptr[ADDR_WIDTH-1:0]];
    assign dout_valid = ~empty;
`else
    // registered read port: one-cycle latency, dout holds between pops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout       <= rd_acc ? mem[rd_ptr[ADDR_WIDTH-1:0]] : dout;
            dout_valid <= rd_acc;
        end
    end
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: scoreboard bench for sync_fifo_param (DEPTH=16, AF=12, AE=2)
module tb_sync_fifo_param;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] din = '0;
    logic [7:0] dout;
    logic       dout_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;
    logic [7:0] exp_q[$];
    logic [7:0] m_dout;
    logic       m_valid, m_ovf, m_unf;
    int         n_chk = 0;
    int         n_pass = 0;

    sync_fifo_param dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_all(input string ph);
        int n = exp_q.size();
`ifdef FWFT_EN
        m_dout  = n ? exp_q[0] : 8'h00;
        m_valid = n != 0;
`endif
        check({ph, ".count"}, count, n);
        check({ph, ".full"}, full, n == 16);
        check({ph, ".empty"}, empty, n == 0);
        check({ph, ".almost_full"}, almost_full, n >= 12);
        check({ph, ".almost_empty"}, almost_empty, n <= 2);
        check({ph, ".overflow"}, overflow, m_ovf);
        check({ph, ".underflow"}, underflow, m_unf);
        check({ph, ".dout"}, dout, m_dout);
        check({ph, ".dout_valid"}, dout_valid, m_valid);
    endtask

    task automatic cycle(input string ph, input logic we, input logic re, input logic [7:0] d);
        logic ra, wa;
        wr_en = we;
        rd_en = re;
        din   = d;
        ra = re && exp_q.size() != 0;
        wa = we && (exp_q.size() < 16 || ra);
        m_ovf = m_ovf | (we && !wa);
        m_unf = m_unf | (re && exp_q.size() == 0);
`ifndef FWFT_EN
        m_valid = ra;
`endif
        if (ra) m_dout = exp_q.pop_front();
        if (wa) exp_q.push_back(d);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_all(ph);
    endtask

    task automatic do_reset(input logic we);
        rst_n = 1'b0;
        wr_en = we;
        din   = 8'h77;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr_en = 1'b0;
        exp_q.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        check_all("reset");
    endtask

    initial begin
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) cycle("idle", 1'b0, 1'b0, 8'h00);
        for (int i = 1; i <= 16; i++) cycle("fill", 1'b1, 1'b0, 8'(i));
        cycle("ovf", 1'b1, 1'b0, 8'hFF);
        for (int i = 0; i < 16; i++) cycle("drain", 1'b0, 1'b1, 8'h00);
        cycle("idle2", 1'b0, 1'b0, 8'h00);
        cycle("unf", 1'b0, 1'b1, 8'h00);
        do_reset(1'b0);
        for (int i = 0; i < 16; i++) cycle("fill2", 1'b1, 1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 20; i++) cycle("rw_full", 1'b1, 1'b1, 8'(8'h20 + i));
        for (int i = 0; i < 17; i++) cycle("drain2", 1'b0, 1'b1, 8'h00);
        cycle("rw_empty", 1'b1, 1'b1, 8'h5A);
        cycle("rw_empty_rd", 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) cycle("pre_rst", 1'b1, 1'b0, 8'(8'h60 + i));
        do_reset(1'b1);
        cycle("wr_a5", 1'b1, 1'b0, 8'hA5);
        cycle("hold_a5", 1'b0, 1'b0, 8'h00);
        cycle("pop_a5", 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 300; i++)
            cycle("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
